// File: rtl/div_dispatch_if.sv
// Host and divider signal bundle for div_dispatch.
// The slave modport is the dispatcher; the master modport is whoever drives the host and divider sides.
interface div_dispatch_if #(
    parameter int W     = 10,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_valid;
    logic          in_ready;
    logic          div_start;
    logic [W-1:0]  div_a;
    logic [W-1:0]  div_b;
    logic          div_busy;
    logic          div_valid;
    logic [W-1:0]  div_q;
    logic          div_dvz;
    logic          div_ovf;
    logic [W-1:0]  out_q;
    logic          out_dvz;
    logic          out_ovf;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] pending;
    logic          proto_err;

    modport slave (
        input  in_a, in_b, in_valid, div_busy, div_valid, div_q, div_dvz, div_ovf, out_ready,
        output in_ready, div_start, div_a, div_b, out_q, out_dvz, out_ovf, out_valid,
               pending, proto_err
    );

    modport master (
        output in_a, in_b, in_valid, div_busy, div_valid, div_q, div_dvz, div_ovf, out_ready,
        input  in_ready, div_start, div_a, div_b, out_q, out_dvz, out_ovf, out_valid,
               pending, proto_err
    );
endinterface

// File: rtl/div_dispatch.sv
// Operand FIFO and single-outstanding issue/capture sequencer in front of the sequential divider.
// Results are held in one output register until the host drains them.
module div_dispatch #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         sclr,
    div_dispatch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [2*W-1:0]  mem_q [DEPTH];

    logic            start_q;
    logic [W-1:0]    div_a_q;
    logic [W-1:0]    div_b_q;
    logic [W-1:0]    res_q_q;
    logic            res_dvz_q;
    logic            res_ovf_q;
    logic            res_valid_q;
    logic            perr_q;

    logic            in_ready_s;
    logic            push_s;
    logic            pop_s;
    logic [2*W-1:0]  head_s;

    assign in_ready_s = sclr && (count_q < CW'(DEPTH));
    assign push_s     = bus.in_valid && in_ready_s;
    // Issue only with nothing outstanding and an empty result register.
    assign pop_s      = (state_q == IDLE) && (count_q != '0) && !bus.div_busy && !res_valid_q;
    assign head_s     = mem_q[rd_ptr_q];

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Operand storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
        end
    end

    // Pointers, issue/capture FSM, result register and sticky protocol error.
    always_ff @(posedge clk) begin
        if (!sclr) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            start_q     <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            res_q_q     <= '0;
            res_dvz_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            count_q <= count_d;
            start_q <= 1'b0;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            if (bus.div_valid && (state_q != WAIT)) begin
                perr_q <= 1'b1;
            end
            if (res_valid_q && bus.out_ready) begin
                res_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        div_a_q <= head_s[2*W-1:W];
                        div_b_q <= head_s[W-1:0];
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.div_valid) begin
                        res_q_q     <= bus.div_q;
                        res_dvz_q   <= bus.div_dvz;
                        res_ovf_q   <= bus.div_ovf;
                        res_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.div_start = start_q;
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign bus.out_q     = res_q_q;
    assign bus.out_dvz   = res_dvz_q;
    assign bus.out_ovf   = res_ovf_q;
    assign bus.out_valid = res_valid_q;
    assign bus.pending   = count_q;
    assign bus.proto_err = perr_q;
endmodule
